// File: rtl/rbm_pkg.sv
// Shared constants and types for the RBM Gibbs-sampling datapath
// (sigmoid LUT -> Bernoulli sampler -> state buffer).
package rbm_pkg;

  localparam int unsigned P_W_DEFAULT    = 16;
  localparam int unsigned PACK_W_DEFAULT = 32;
  localparam int unsigned LFSR_W_DEFAULT = 32;

  // x^32 + x^22 + x^2 + x + 1, maximal-length Galois form
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] SEED_DEFAULT = 32'hACE1_1234;

  // Unsigned Q0.16 probability as emitted by the sigmoid LUT
  typedef logic [P_W_DEFAULT-1:0] prob_t;

endpackage

// File: rtl/bernoulli_sampler_if.sv
// Probability-in / packed-word-out stream bundle for the Bernoulli sampler.
// The sampler uses the slave view; the sigmoid/state-buffer side uses master.
interface bernoulli_sampler_if
  import rbm_pkg::*;
#(
  parameter int P_W    = P_W_DEFAULT,
  parameter int PACK_W = PACK_W_DEFAULT
);

  localparam int NB_W = $clog2(PACK_W) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [P_W-1:0]    in_p;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [PACK_W-1:0] out_word;
  logic [NB_W-1:0]   out_nbits;
  logic              out_last;

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_word, out_nbits, out_last
  );

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_nbits, out_last
  );

endinterface

// File: rtl/lfsr_galois.sv
// Galois LFSR that advances one step per request; a loaded all-zero seed
// is replaced by DEFAULT so the register can never lock up.
module lfsr_galois #(
  parameter int           W       = 32,
  parameter logic [W-1:0] TAPS    = rbm_pkg::LFSR_TAPS,
  parameter logic [W-1:0] DEFAULT = rbm_pkg::SEED_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state
);

  logic [W-1:0] r_state;
  logic [W-1:0] w_next;
  logic [W-1:0] w_seed;

  assign w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
  assign w_seed = (load_val == '0) ? DEFAULT : load_val;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DEFAULT;
    end else if (load) begin
      r_state <= w_seed;
    end else if (step) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule

// File: rtl/bernoulli_sampler.sv
// Draws one binary unit state per accepted probability (rnd < p) and packs
// the bits LSB-first into words for the Gibbs state-vector buffer.
module bernoulli_sampler
  import rbm_pkg::*;
#(
  parameter int                P_W          = P_W_DEFAULT,
  parameter int                PACK_W       = PACK_W_DEFAULT,
  parameter int                LFSR_W       = LFSR_W_DEFAULT,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = rbm_pkg::LFSR_TAPS,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = rbm_pkg::SEED_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       seed_we,
  input  logic [LFSR_W-1:0]          seed,
  bernoulli_sampler_if.slave         bus
);

  localparam int CNT_W = $clog2(PACK_W) + 1;

  logic [LFSR_W-1:0] w_lfsr;
  logic [P_W-1:0]    w_rnd;
  logic              w_accept;
  logic              w_bit;
  logic              w_flush;
  logic [PACK_W-1:0] w_pack_next;

  logic [PACK_W-1:0] r_pack;
  logic [CNT_W-1:0]  r_count;
  logic              r_out_valid;
  logic [PACK_W-1:0] r_out_word;
  logic [CNT_W-1:0]  r_out_nbits;
  logic              r_out_last;

  // A seed load wins over the accept-advance; the sample below still sees
  // the pre-load state because it reads the current register value.
  lfsr_galois #(
    .W       (LFSR_W),
    .TAPS    (LFSR_TAPS),
    .DEFAULT (SEED_DEFAULT)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_we),
    .load_val (seed),
    .step     (w_accept),
    .state    (w_lfsr)
  );

  generate
    if (LFSR_W > P_W) begin : g_lfsr_hi
      logic w_unused_lfsr_hi;
      assign w_unused_lfsr_hi = ^w_lfsr[LFSR_W-1:P_W];
    end
  endgenerate

  assign w_rnd    = w_lfsr[P_W-1:0];
  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept = bus.in_valid && bus.in_ready;

  // p = all-ones means probability 1.0, which the strict compare cannot reach
  assign w_bit = (bus.in_p == '1) || (w_rnd < bus.in_p);

  assign w_pack_next = r_pack | ({{(PACK_W-1){1'b0}}, w_bit} << r_count);
  assign w_flush     = w_accept &&
                       (bus.in_last || (r_count == CNT_W'(PACK_W - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      if (w_flush) begin
        r_pack  <= '0;
        r_count <= '0;
      end else begin
        r_pack  <= w_pack_next;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // A flush can only occur when the slot is free or draining this edge,
  // so loading it never overwrites an unconsumed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_nbits <= '0;
      r_out_last  <= 1'b0;
    end else if (w_flush) begin
      r_out_valid <= 1'b1;
      r_out_word  <= w_pack_next;
      r_out_nbits <= r_count + CNT_W'(1);
      r_out_last  <= bus.in_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_word  = r_out_word;
  assign bus.out_nbits = r_out_nbits;
  assign bus.out_last  = r_out_last;

endmodule

// File: doc/bernoulli_sampler.md
Name: bernoulli_sampler

Overview:
Consumes the Q0.16 probability stream produced by the sigmoid stage and draws binary unit states for RBM Gibbs sampling. Each accepted probability p is compared against a pseudo-random value from an internal Galois LFSR. The sampled bits are packed LSB-first into words for the hidden/visible state buffer.
The block sits between the sigmoid LUT output and the state-vector write port of the Gibbs loop.

Parameters:
P_W, 16, probability width (unsigned Q0.P_W).
PACK_W, 32, output word width (bits per packed word).
LFSR_W, 32, LFSR state width; must be >= P_W.
LFSR_TAPS, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).
SEED_DEFAULT, 32'hACE1_1234, reset seed; also replaces any all-zero seed.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
seed_we  in  1  load seed into LFSR this cycle.
seed  in  LFSR_W  seed value.
in_valid  in  1  probability valid.
in_ready  out  1  sampler can accept.
in_p  in  P_W  probability, Q0.P_W.
in_last  in  1  final unit of the vector.
out_valid  out  1  packed word valid.
out_ready  in  1  downstream accepts.
out_word  out  PACK_W  sampled bits; bit i = i-th accepted unit of the word.
out_nbits  out  $clog2(PACK_W)+1  number of valid bits in out_word, 1..PACK_W.
out_last  out  1  word contains the vector's last unit.

Behaviour:
- Reset values: lfsr=SEED_DEFAULT, pack register=0, bit count=0, out_valid=0, out_word=0, out_nbits=0, out_last=0. in_ready=1 out of reset.
- in_ready = !out_valid || out_ready (one output slot, no skid buffer). Transfer rule: in_valid && in_ready.
- Sample on accept: rnd = lfsr[P_W-1:0] (state before advance); bit = (in_p == all-ones) ? 1 : (rnd < in_p), unsigned compare. in_p=0 always gives 0.
- The LFSR advances exactly one Galois step per accepted input: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0). It holds otherwise, so sequences are deterministic per seed.
- seed_we loads seed (or SEED_DEFAULT if seed==0) and takes priority over an accept-advance in the same cycle. The sample in that cycle still uses the old state.
- Packing: each accepted bit is placed at index = count; count increments.
- When count reaches PACK_W, or in_last is accepted, the word moves to the output register on that same edge: out_valid=1 the next cycle, out_nbits=count+1, out_last=in_last. The pack register and count are then cleared.
- Unused high bits of a partial word are 0.
- Latency: out_valid rises 1 cycle after the accept that completes the word.
- Output held stable while out_valid && !out_ready. out_valid clears on handshake unless a new word is loaded on the same edge (back-to-back allowed).
- in_last with count==PACK_W-1 produces a single full word with out_last=1. No extra empty word is ever emitted.
- Async reset mid-vector discards the partial word and pending output. seed_we does not affect the pack state.

Decomposition:
- Package rbm_pkg: P_W/PACK_W defaults, LFSR_TAPS and SEED_DEFAULT constants, prob_t (logic [P_W-1:0]) typedef shared with the sigmoid LUT output.
- Sub-module lfsr_galois: parameters W, TAPS, DEFAULT. Ports: clk, rst_n, load, load_val, step, state. The zero-seed substitution lives inside it.

Test Plan:
- Reset then seed_we=1, seed=0 → LFSR state = 32'hACE1_1234. Feed 32 inputs with in_p=16'hFFFF → one word: out_word=32'hFFFF_FFFF, out_nbits=32, out_last=0.
- 32 inputs with in_p=0, last on the 32nd → out_word=0, out_nbits=32, out_last=1, and exactly one word emitted.
- 5 inputs with in_p=16'hFFFF, in_last on the 5th → out_word=32'h0000_001F, out_nbits=5, out_last=1.
- Seed 32'h1, 64 inputs with in_p=16'h8000 → bits match a reference-model LFSR bit-exact. The ones fraction over 4096 samples is within 0.5±0.03.
- Hold out_ready=0 with a word pending → in_ready=0, the output stays stable, no input is lost, and the LFSR does not step. Release → in_ready=1 the same cycle.
- Assert rst_n low mid-word after 10 accepts → out_valid=0 and count cleared. The next vector starts at bit 0 with the LFSR at SEED_DEFAULT.
